// File: rtl/rv32_e_div_sequencer.sv
// Multi-cycle radix-2 restoring divider sequencer for RV32M DIV/DIVU/REM/REMU in the execute stage.
// Optional early-out for trivial quotients is enabled by defining RV32_DIV_EARLY_OUT_EN.
module rv32_e_div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

`ifdef RV32_DIV_EARLY_OUT_EN
    localparam bit EarlyOutEn = 1'b1;
`else
    localparam bit EarlyOutEn = 1'b0;
`endif

    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Special cases (b==0, INT_MIN/-1) take precedence over the sign correction.
    function automatic logic [XLEN-1:0] fix_result(
        input logic            is_rem,
        input logic            neg_q,
        input logic            neg_r,
        input logic            b_zero,
        input logic            ovf,
        input logic [XLEN-1:0] a_raw,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem
    );
        logic [XLEN-1:0] r;
        if (b_zero) begin
            r = is_rem ? a_raw : {XLEN{1'b1}};
        end else if (ovf) begin
            r = is_rem ? {XLEN{1'b0}} : IntMin;
        end else if (is_rem) begin
            r = neg_r ? negate(rem) : rem;
        end else begin
            r = neg_q ? negate(quo) : quo;
        end
        return r;
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              is_rem_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic              b_zero_r;
    logic              ovf_r;
    logic [XLEN-1:0]   a_raw_r;
    logic [XLEN-1:0]   div_r;
    logic [XLEN-1:0]   quo_r;
    logic [XLEN-1:0]   rem_r;
    logic              valid_r;
    logic [XLEN-1:0]   result_r;

    logic              signed_s;
    logic              neg_a_s;
    logic              neg_b_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic              b_zero_s;
    logic              ovf_s;
    logic              early_s;
    logic [XLEN-1:0]   early_res_s;
    logic [XLEN:0]     rem_sh_s;
    logic              ge_s;
    logic [XLEN-1:0]   rem_nx_s;
    logic [XLEN-1:0]   quo_nx_s;
    logic [XLEN-1:0]   final_res_s;

    // Operand decode at issue: sign flags, magnitudes and the early-out decision.
    always_comb begin
        signed_s    = ~op_i[0];
        neg_a_s     = signed_s & src_a_i[XLEN-1];
        neg_b_s     = signed_s & src_b_i[XLEN-1];
        mag_a_s     = neg_a_s ? negate(src_a_i) : src_a_i;
        mag_b_s     = neg_b_s ? negate(src_b_i) : src_b_i;
        b_zero_s    = (src_b_i == {XLEN{1'b0}});
        ovf_s       = signed_s & (src_a_i == IntMin) & (src_b_i == {XLEN{1'b1}});
        early_s     = EarlyOutEn & (b_zero_s | (mag_a_s < mag_b_s));
        early_res_s = fix_result(op_i[1], neg_a_s ^ neg_b_s, neg_a_s, b_zero_s, ovf_s,
                                 src_a_i, {XLEN{1'b0}}, mag_a_s);
    end

    // One restoring step; the remainder needs an extra bit before the compare.
    always_comb begin
        rem_sh_s    = {rem_r, quo_r[XLEN-1]};
        ge_s        = (rem_sh_s >= {1'b0, div_r});
        rem_nx_s    = ge_s ? (rem_sh_s[XLEN-1:0] - div_r) : rem_sh_s[XLEN-1:0];
        quo_nx_s    = {quo_r[XLEN-2:0], ge_s};
        final_res_s = fix_result(is_rem_r, neg_q_r, neg_r_r, b_zero_r, ovf_r,
                                 a_raw_r, quo_nx_s, rem_nx_s);
    end

    // Sequencer FSM, iteration counter and datapath registers; flush wins over everything.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            b_zero_r <= 1'b0;
            ovf_r    <= 1'b0;
            a_raw_r  <= {XLEN{1'b0}};
            div_r    <= {XLEN{1'b0}};
            quo_r    <= {XLEN{1'b0}};
            rem_r    <= {XLEN{1'b0}};
            valid_r  <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else if (flush_i) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (start_i) begin
                        is_rem_r <= op_i[1];
                        neg_q_r  <= neg_a_s ^ neg_b_s;
                        neg_r_r  <= neg_a_s;
                        b_zero_r <= b_zero_s;
                        ovf_r    <= ovf_s;
                        a_raw_r  <= src_a_i;
                        div_r    <= mag_b_s;
                        quo_r    <= mag_a_s;
                        rem_r    <= {XLEN{1'b0}};
                        cnt_r    <= CNT_W'(XLEN - 1);
                        if (early_s) begin
                            result_r <= early_res_s;
                            valid_r  <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem_r <= rem_nx_s;
                    quo_r <= quo_nx_s;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        result_r <= final_res_s;
                        valid_r  <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_o  = ((state_r == ST_IDLE) & start_i & ~flush_i) | (state_r == ST_CALC);
    assign valid_o  = valid_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_rv32_e_div_sequencer.sv
// Randomized self-checking bench for rv32_e_div_sequencer against an arithmetic reference model.
module tb_rv32_e_div_sequencer;
    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  op_i    = 2'd0;
    logic [31:0] src_a_i = 32'd0;
    logic [31:0] src_b_i = 32'd0;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] result_o;

    int total = 0;
    int bad   = 0;

`ifdef RV32_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    rv32_e_div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
        .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    // RISC-V M-extension semantics, straight from the ISA rules.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic sgn;
        logic is_rem;
        sgn    = ~o[0];
        is_rem = o[1];
        if (y == 32'd0) return is_rem ? x : 32'hFFFFFFFF;
        if (sgn && x == 32'h80000000 && y == 32'hFFFFFFFF) return is_rem ? 32'd0 : 32'h80000000;
        if (sgn) return is_rem ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
        return is_rem ? (x % y) : (x / y);
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (~o[0] && x[31]) ? -x : x;
        mb = (~o[0] && y[31]) ? -y : y;
        if (EARLY && (y == 32'd0 || ma < mb)) return 1;
        return 33;
    endfunction

    // Issue one op at the current cycle; report result, cycles to valid (-1 on timeout), stall cycles.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit keep,
                          output logic [31:0] res, output int lat, output int stl);
        start_i = 1'b1; op_i = o; src_a_i = x; src_b_i = y;
        lat = -1; stl = 0; res = 32'd0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (stall_o) stl++;
            if (valid_o) begin
                lat = k; res = result_o;
                break;
            end
            @(posedge clk_i); #1;
        end
        if (lat >= 0) begin
            @(posedge clk_i); #1;
        end
        if (!keep) start_i = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n_i = 1'b0;
        #10;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        total++; if (result_o !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", result_o); end
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  d_op [10] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd1};
        logic [31:0] d_a  [10] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFB,
                                   32'h80000000, 32'h80000000, 32'd100, 32'd100, 32'd3};
        logic [31:0] d_b  [10] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'd0,
                                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd10};
        logic [31:0] res;
        int lat, stl, el;
        for (int i = 0; i < 10; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], 1'b0, res, lat, stl);
            el = model_lat(d_op[i], d_a[i], d_b[i]);
            total++; if (res !== model(d_op[i], d_a[i], d_b[i])) begin
                bad++; $display("FAIL dir%0d_result: got %h want %h", i, res, model(d_op[i], d_a[i], d_b[i])); end
            total++; if (lat !== el) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, el); end
            total++; if (stl !== el) begin bad++; $display("FAIL dir%0d_stall_cycles: got %0d want %0d", i, stl, el); end
            @(negedge clk_i);
            total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL dir%0d_pulse: got %b want 0", i, valid_o); end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_random();
        logic [31:0] res, x, y;
        logic [1:0]  o;
        int lat, stl;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            if ($urandom_range(0, 7) == 0) x = 32'h80000000;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'hFFFFFFFF;
                2: y = 32'($urandom_range(1, 20));
                3: y = $urandom >> 16;
                4: y = x;
                default: y = $urandom;
            endcase
            run_op(o, x, y, 1'b0, res, lat, stl);
            total++; if (res !== model(o, x, y)) begin
                bad++; $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got %h want %h", i, o, x, y, res, model(o, x, y)); end
            total++; if (lat !== model_lat(o, x, y)) begin
                bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, model_lat(o, x, y)); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, stl, seen;
        start_i = 1'b1; op_i = 2'd1; src_a_i = 32'hFFFF0000; src_b_i = 32'd3;
        for (int k = 0; k < 10; k++) begin @(posedge clk_i); #1; end
        flush_i = 1'b1; start_i = 1'b0;
        @(posedge clk_i); #1 flush_i = 1'b0;
        @(negedge clk_i);
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", valid_o); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk_i); if (valid_o) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_valid: got %0d pulses want 0", seen); end
        @(posedge clk_i); #1;
        run_op(2'd1, 32'd9, 32'd3, 1'b0, res, lat, stl);
        total++; if (res !== model(2'd1, 32'd9, 32'd3)) begin bad++; $display("FAIL flush_after: got %h want %h", res, model(2'd1, 32'd9, 32'd3)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r0, r1;
        int l0, l1, s0, s1, seen;
        run_op(2'd1, 32'd20, 32'd4, 1'b1, r0, l0, s0);
        run_op(2'd3, 32'd20, 32'd6, 1'b0, r1, l1, s1);
        total++; if (r0 !== model(2'd1, 32'd20, 32'd4)) begin bad++; $display("FAIL b2b_first: got %h want %h", r0, model(2'd1, 32'd20, 32'd4)); end
        total++; if (r1 !== model(2'd3, 32'd20, 32'd6)) begin bad++; $display("FAIL b2b_second: got %h want %h", r1, model(2'd3, 32'd20, 32'd6)); end
        total++; if (l1 !== model_lat(2'd3, 32'd20, 32'd6)) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", l1, model_lat(2'd3, 32'd20, 32'd6)); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk_i); if (valid_o) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL b2b_duplicate: got %0d extra pulses want 0", seen); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat, stl, seen;
        start_i = 1'b1; op_i = 2'd0; src_a_i = 32'hFFFFFC18; src_b_i = 32'd7;
        for (int k = 0; k < 10; k++) begin @(posedge clk_i); #1; end
        rst_n_i = 1'b0; start_i = 1'b0;
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", valid_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rstmid_stall: got %b want 0", stall_o); end
        total++; if (result_o !== 32'd0) begin bad++; $display("FAIL rstmid_result: got %h want 0", result_o); end
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk_i); if (valid_o) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", seen); end
        @(posedge clk_i); #1;
        run_op(2'd1, 32'd3, 32'd10, 1'b0, res, lat, stl);
        total++; if (res !== model(2'd1, 32'd3, 32'd10)) begin bad++; $display("FAIL early_result: got %h want %h", res, model(2'd1, 32'd3, 32'd10)); end
        total++; if (lat !== model_lat(2'd1, 32'd3, 32'd10)) begin bad++; $display("FAIL early_latency: got %0d want %0d", lat, model_lat(2'd1, 32'd3, 32'd10)); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
